// File: rtl/ecc_secded_channel_if.sv
// Producer/consumer bundle of the SECDED channel: input word, error-injection mask,
// corrected output word with flags/syndrome, and the error counters.
interface ecc_secded_channel_if #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 16
);
   function automatic int calc_p(input int d);
      int r;
      r = 7;
      for (int p = 7; p >= 1; p--) begin
         if ((1 << p) >= d + p + 1) r = p;
      end
      return r;
   endfunction

   localparam int P          = calc_p(DATA_WIDTH);
   localparam int CODE_WIDTH = DATA_WIDTH + P + 1;

   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in_data;
   logic [CODE_WIDTH-1:0] inj_mask;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_err_single;
   logic                  out_err_double;
   logic [P-1:0]          out_syndrome;
   logic                  cnt_clr;
   logic [CNT_WIDTH-1:0]  single_cnt;
   logic [CNT_WIDTH-1:0]  double_cnt;

   modport slave (
      input  in_valid, in_data, inj_mask, out_ready, cnt_clr,
      output in_ready, out_valid, out_data, out_err_single, out_err_double,
             out_syndrome, single_cnt, double_cnt
   );

   modport master (
      output in_valid, in_data, inj_mask, out_ready, cnt_clr,
      input  in_ready, out_valid, out_data, out_err_single, out_err_double,
             out_syndrome, single_cnt, double_cnt
   );
endinterface

// File: rtl/ecc_secded_channel.sv
// SECDED channel: encode+inject in s1, decode/correct in s2; 2-cycle latency, 1 word/cycle,
// combinational ready so a full stalled pipeline deasserts in_ready without losing words.
module ecc_secded_channel #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 16
) (
   input logic                  clk,
   input logic                  rst,
   ecc_secded_channel_if.slave  bus
);
   function automatic int calc_p(input int d);
      int r;
      r = 7;
      for (int p = 7; p >= 1; p--) begin
         if ((1 << p) >= d + p + 1) r = p;
      end
      return r;
   endfunction

   localparam int P  = calc_p(DATA_WIDTH);
   localparam int CW = DATA_WIDTH + P + 1;

   typedef logic [CW-1:0]         code_t;
   typedef logic [DATA_WIDTH-1:0] data_t;

   // Data fills the non-power-of-two positions LSB-first; bit 0 is overall parity.
   function automatic code_t encode(input data_t d);
      code_t c;
      logic  par;
      int    j;
      c = '0;
      j = 0;
      for (int k = 1; k < CW; k++) begin
         if ((k & (k - 1)) != 0) begin
            c[k] = d[j];
            j++;
         end
      end
      for (int i = 0; i < P; i++) begin
         par = 1'b0;
         for (int k = 1; k < CW; k++) begin
            if (((k >> i) & 1) == 1 && k != (1 << i)) par = par ^ c[k];
         end
         c[1 << i] = par;
      end
      c[0] = ^c[CW-1:1];
      return c;
   endfunction

   function automatic data_t extract(input code_t c);
      data_t d;
      int    j;
      d = '0;
      j = 0;
      for (int k = 1; k < CW; k++) begin
         if ((k & (k - 1)) != 0) begin
            d[j] = c[k];
            j++;
         end
      end
      return d;
   endfunction

   logic                 r_v1;
   code_t                r_c1;
   logic                 r_v2;
   data_t                r_data;
   logic                 r_err_s;
   logic                 r_err_d;
   logic [P-1:0]         r_syn;
   logic [CNT_WIDTH-1:0] r_scnt;
   logic [CNT_WIDTH-1:0] r_dcnt;

   logic                 w_s2_adv;
   logic                 w_s1_adv;
   logic                 w_in_rdy;
   logic                 w_accept;
   logic                 w_out_hs;
   logic [P-1:0]         w_syn;
   logic                 w_q;
   code_t                w_fix;
   logic                 w_single;
   logic                 w_double;
   data_t                w_data;

   assign w_s2_adv = !r_v2 || bus.out_ready;
   assign w_s1_adv = r_v1 && w_s2_adv;
   assign w_in_rdy = !r_v1 || w_s1_adv;
   assign w_accept = bus.in_valid && w_in_rdy;
   assign w_out_hs = r_v2 && bus.out_ready;

   always_comb begin
      w_syn    = '0;
      w_q      = ^r_c1;
      w_fix    = r_c1;
      w_single = 1'b0;
      w_double = 1'b0;
      for (int k = 1; k < CW; k++) begin
         if (r_c1[k]) w_syn = w_syn ^ P'(k);
      end
      if (w_q) begin
         if (w_syn == '0) begin
            w_single = 1'b1;
         end else if (int'(w_syn) <= CW - 1) begin
            w_single = 1'b1;
            for (int k = 1; k < CW; k++) begin
               if (k == int'(w_syn)) w_fix[k] = ~r_c1[k];
            end
         end else begin
            w_double = 1'b1;
         end
      end else if (w_syn != '0) begin
         w_double = 1'b1;
      end
      w_data = extract(w_fix);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_v1 <= 1'b0;
         r_c1 <= '0;
      end else if (w_in_rdy) begin
         r_v1 <= bus.in_valid;
         if (w_accept) r_c1 <= encode(bus.in_data) ^ bus.inj_mask;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_v2    <= 1'b0;
         r_data  <= '0;
         r_err_s <= 1'b0;
         r_err_d <= 1'b0;
         r_syn   <= '0;
      end else if (w_s2_adv) begin
         r_v2 <= r_v1;
         if (r_v1) begin
            r_data  <= w_data;
            r_err_s <= w_single;
            r_err_d <= w_double;
            r_syn   <= w_syn;
         end
      end
   end

   // Clear wins over a same-edge increment; counts stick at all-ones.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_scnt <= '0;
         r_dcnt <= '0;
      end else if (bus.cnt_clr) begin
         r_scnt <= '0;
         r_dcnt <= '0;
      end else if (w_out_hs) begin
         if (r_err_s && r_scnt != '1) r_scnt <= r_scnt + 1'b1;
         if (r_err_d && r_dcnt != '1) r_dcnt <= r_dcnt + 1'b1;
      end
   end

   assign bus.in_ready       = w_in_rdy;
   assign bus.out_valid      = r_v2;
   assign bus.out_data       = r_data;
   assign bus.out_err_single = r_err_s;
   assign bus.out_err_double = r_err_d;
   assign bus.out_syndrome   = r_syn;
   assign bus.single_cnt     = r_scnt;
   assign bus.double_cnt     = r_dcnt;
endmodule

// File: tb/tb_ecc_secded_channel.sv
// Directed bench for ecc_secded_channel at DATA_WIDTH=8 (13-bit codeword), CNT_WIDTH=2.
module tb_ecc_secded_channel;
   logic clk;
   logic rst;
   int   checks;
   int   errors;
   int   sc;
   int   dc;

   ecc_secded_channel_if #(.DATA_WIDTH(8), .CNT_WIDTH(2)) bus ();

   ecc_secded_channel #(.DATA_WIDTH(8), .CNT_WIDTH(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One word through an idle pipeline: checks 2-cycle latency, result, and counters after handshake.
   task automatic xfer(input logic [7:0] d, input logic [12:0] m, input logic [7:0] exp_d,
                       input logic exp_s, input logic exp_dbl, input logic [3:0] exp_syn,
                       input logic clr);
      bus.in_valid  = 1'b1;
      bus.in_data   = d;
      bus.inj_mask  = m;
      bus.out_ready = 1'b1;
      #1;
      chk("in_ready_idle", 64'(bus.in_ready), 64'd1);
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_data  = 8'hFF;
      bus.inj_mask = 13'h1FFF;
      chk("latency_not_yet", 64'(bus.out_valid), 64'd0);
      @(posedge clk);
      @(negedge clk);
      chk("out_valid", 64'(bus.out_valid), 64'd1);
      chk("out_data", 64'(bus.out_data), 64'(exp_d));
      chk("err_single", 64'(bus.out_err_single), 64'(exp_s));
      chk("err_double", 64'(bus.out_err_double), 64'(exp_dbl));
      chk("syndrome", 64'(bus.out_syndrome), 64'(exp_syn));
      bus.cnt_clr = clr;
      @(posedge clk);
      @(negedge clk);
      bus.cnt_clr = 1'b0;
      if (clr) begin
         sc = 0;
         dc = 0;
      end else begin
         if (exp_s && sc != 3) sc++;
         if (exp_dbl && dc != 3) dc++;
      end
      chk("single_cnt", 64'(bus.single_cnt), 64'(sc));
      chk("double_cnt", 64'(bus.double_cnt), 64'(dc));
      chk("drained", 64'(bus.out_valid), 64'd0);
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      sc            = 0;
      dc            = 0;
      rst           = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.inj_mask  = '0;
      bus.out_ready = 1'b0;
      bus.cnt_clr   = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_out_data", 64'(bus.out_data), 64'd0);
      chk("rst_syndrome", 64'(bus.out_syndrome), 64'd0);
      chk("rst_flags", 64'({bus.out_err_single, bus.out_err_double}), 64'd0);
      chk("rst_counts", 64'({bus.single_cnt, bus.double_cnt}), 64'd0);
      chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
      @(negedge clk);

      xfer(8'hA5, 13'h0000, 8'hA5, 1'b0, 1'b0, 4'd0,  1'b0);  // clean
      xfer(8'hA5, 13'h0008, 8'hA5, 1'b1, 1'b0, 4'd3,  1'b0);  // d0 flipped
      xfer(8'hA5, 13'h0001, 8'hA5, 1'b1, 1'b0, 4'd0,  1'b0);  // overall parity bit
      xfer(8'hA5, 13'h0006, 8'hA5, 1'b0, 1'b1, 4'd3,  1'b0);  // positions 1,2
      xfer(8'hA5, 13'h1003, 8'h25, 1'b0, 1'b1, 4'd13, 1'b0);  // odd weight, syndrome past codeword
      xfer(8'hA5, 13'h0100, 8'hA5, 1'b1, 1'b0, 4'd8,  1'b0);  // parity bit 8
      xfer(8'hA5, 13'h1000, 8'hA5, 1'b1, 1'b0, 4'd12, 1'b0);  // top position (d7), count saturates

      bus.cnt_clr = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.cnt_clr = 1'b0;
      sc = 0;
      dc = 0;
      chk("clr_single", 64'(bus.single_cnt), 64'd0);
      chk("clr_double", 64'(bus.double_cnt), 64'd0);

      // Backpressure: fill both stages with the consumer stalled, then release.
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.inj_mask  = '0;
      bus.in_data   = 8'h01;
      #1;
      chk("bp_rdy1", 64'(bus.in_ready), 64'd1);
      @(posedge clk);
      @(negedge clk);
      bus.in_data = 8'h02;
      #1;
      chk("bp_rdy2", 64'(bus.in_ready), 64'd1);
      @(posedge clk);
      @(negedge clk);
      bus.in_data = 8'h03;
      #1;
      chk("bp_full_rdy", 64'(bus.in_ready), 64'd0);
      chk("bp_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_head", 64'(bus.out_data), 64'h01);
      @(posedge clk);
      @(negedge clk);
      chk("bp_hold_data", 64'(bus.out_data), 64'h01);
      chk("bp_hold_rdy", 64'(bus.in_ready), 64'd0);
      bus.out_ready = 1'b1;
      #1;
      chk("bp_release_rdy", 64'(bus.in_ready), 64'd1);
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("bp_out2_v", 64'(bus.out_valid), 64'd1);
      chk("bp_out2", 64'(bus.out_data), 64'h02);
      @(posedge clk);
      @(negedge clk);
      chk("bp_out3_v", 64'(bus.out_valid), 64'd1);
      chk("bp_out3", 64'(bus.out_data), 64'h03);
      @(posedge clk);
      @(negedge clk);
      chk("bp_empty", 64'(bus.out_valid), 64'd0);
      chk("bp_counts", 64'({bus.single_cnt, bus.double_cnt}), 64'd0);

      // Saturation at 3, then clear on the same edge as a counted handshake.
      for (int i = 0; i < 5; i++) xfer(8'h5A, 13'h0008, 8'h5A, 1'b1, 1'b0, 4'd3, 1'b0);
      xfer(8'h5A, 13'h0008, 8'h5A, 1'b1, 1'b0, 4'd3, 1'b1);
      xfer(8'h77, 13'h0020, 8'h77, 1'b1, 1'b0, 4'd5, 1'b0);

      // Reset with both stages occupied.
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.inj_mask  = '0;
      bus.in_data   = 8'h11;
      @(posedge clk);
      @(negedge clk);
      bus.in_data = 8'h22;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("mid_full", 64'(bus.out_valid), 64'd1);
      #1;
      rst = 1'b0;
      #1;
      chk("async_valid", 64'(bus.out_valid), 64'd0);
      chk("async_data", 64'(bus.out_data), 64'd0);
      chk("async_single_cnt", 64'(bus.single_cnt), 64'd0);
      chk("async_flags", 64'({bus.out_err_single, bus.out_err_double, bus.out_syndrome}), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      sc  = 0;
      dc  = 0;
      @(negedge clk);
      chk("post_rst_idle", 64'(bus.out_valid), 64'd0);
      xfer(8'h3C, 13'h0000, 8'h3C, 1'b0, 1'b0, 4'd0, 1'b0);
      repeat (2) @(negedge clk);
      chk("no_stale", 64'(bus.out_valid), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
